// File: rtl/age_ordered_rs_pkg.sv
// Shared constants and helpers for the age-ordered reservation station.
package age_ordered_rs_pkg;

  localparam int unsigned RS_N_LINE = 16;
  localparam int unsigned RS_N_SRC  = 2;
  localparam int unsigned RS_N_WAKE = 2;
  localparam int unsigned RS_TAG_W  = 8;
  localparam int unsigned RS_DATA_W = 32;
  localparam int unsigned RS_PAY_W  = 48;

  // Slot-index width; never zero so a 1-entry index still has a bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix: tracks relative age of busy entries and picks the oldest ready one.
module rs_age_matrix
  import age_ordered_rs_pkg::*;
#(
  parameter int unsigned N_LINE = RS_N_LINE,
  parameter int unsigned IDX_W  = idx_w(N_LINE)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alloc_en,
  input  logic [IDX_W-1:0]  alloc_idx,
  input  logic [N_LINE-1:0] busy,
  input  logic [N_LINE-1:0] ready,
  output logic [IDX_W-1:0]  oldest_idx,
  output logic              any_ready
);

  // older_q[i][j] = 1 : entry i is older than entry j
  logic [N_LINE-1:0] older_q [N_LINE];

  // New entry is younger than every current occupant; its own row starts clean.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(N_LINE); i++) older_q[i] <= '0;
    end else if (alloc_en) begin
      for (int i = 0; i < int'(N_LINE); i++) begin
        if (IDX_W'(i) == alloc_idx) older_q[i] <= '0;
        else if (busy[i])           older_q[i][alloc_idx] <= 1'b1;
      end
    end
  end

  // An entry wins when it is ready and no ready entry is older than it.
  always_comb begin
    logic blocked;
    blocked    = 1'b0;
    any_ready  = |ready;
    oldest_idx = '0;
    for (int i = 0; i < int'(N_LINE); i++) begin
      blocked = 1'b0;
      for (int j = 0; j < int'(N_LINE); j++) begin
        if (ready[j] && older_q[j][i]) blocked = 1'b1;
      end
      if (ready[i] && !blocked) oldest_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/age_ordered_rs.sv
// Reservation station with dispatch bypass, multi-port wakeup and oldest-first issue.
module age_ordered_rs
  import age_ordered_rs_pkg::*;
#(
  parameter int unsigned N_LINE = RS_N_LINE,
  parameter int unsigned N_SRC  = RS_N_SRC,
  parameter int unsigned N_WAKE = RS_N_WAKE,
  parameter int unsigned TAG_W  = RS_TAG_W,
  parameter int unsigned DATA_W = RS_DATA_W,
  parameter int unsigned PAY_W  = RS_PAY_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flash,
  input  logic                       in_en,
  output logic                       in_reject,
  input  logic [PAY_W-1:0]           in_payload,
  input  logic [N_SRC-1:0]           in_src_valid,
  input  logic [N_SRC*TAG_W-1:0]     in_src_tag,
  input  logic [N_SRC*DATA_W-1:0]    in_src_data,
  input  logic [N_WAKE-1:0]          wake_en,
  input  logic [N_WAKE*TAG_W-1:0]    wake_tag,
  input  logic [N_WAKE*DATA_W-1:0]   wake_data,
  output logic                       issue_en,
  input  logic                       issue_reject,
  output logic [PAY_W-1:0]           issue_payload,
  output logic [N_SRC*DATA_W-1:0]    issue_src_data,
  output logic [$clog2(N_LINE+1)-1:0] count
);

  localparam int unsigned IDX_W = idx_w(N_LINE);
  localparam int unsigned CNT_W = $clog2(N_LINE + 1);

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } src_t;

  typedef struct packed {
    logic                  busy;
    logic [PAY_W-1:0]      payload;
    src_t [N_SRC-1:0]      src;
  } rs_entry_t;

  rs_entry_t         entry_q [N_LINE];
  rs_entry_t         entry_d [N_LINE];
  logic [CNT_W-1:0]  count_q, count_d;
  logic [N_LINE-1:0] busy, ready;
  logic [IDX_W-1:0]  free_idx, sel_idx;
  logic              any_ready, accept, fire, kill;
  src_t              in_s;

  // A waiting source takes data from the lowest matching wake port; valid ones are kept.
  function automatic src_t wake_capture(input src_t s);
    src_t r;
    r = s;
    if (!s.valid) begin
      for (int p = int'(N_WAKE) - 1; p >= 0; p--) begin
        if (wake_en[p] && (wake_tag[p*TAG_W +: TAG_W] == s.tag)) begin
          r.valid = 1'b1;
          r.data  = wake_data[p*DATA_W +: DATA_W];
        end
      end
    end
    return r;
  endfunction

  // Per-entry occupancy and readiness from registered state.
  always_comb begin
    for (int i = 0; i < int'(N_LINE); i++) begin
      busy[i]  = entry_q[i].busy;
      ready[i] = entry_q[i].busy;
      for (int s = 0; s < int'(N_SRC); s++) ready[i] = ready[i] & entry_q[i].src[s].valid;
    end
  end

  // Lowest-index free slot.
  always_comb begin
    free_idx = '0;
    for (int i = int'(N_LINE) - 1; i >= 0; i--) begin
      if (!entry_q[i].busy) free_idx = IDX_W'(i);
    end
  end

  // Handshake decisions for this cycle.
  always_comb begin
    kill      = reset | flash;
    in_reject = (count_q == CNT_W'(N_LINE));
    accept    = in_en & ~in_reject & ~kill;
    issue_en  = any_ready & ~kill;
    fire      = issue_en & ~issue_reject;
  end

  rs_age_matrix #(.N_LINE(N_LINE), .IDX_W(IDX_W)) u_age (
    .clock      (clock),
    .reset      (reset),
    .alloc_en   (accept),
    .alloc_idx  (free_idx),
    .busy       (busy),
    .ready      (ready),
    .oldest_idx (sel_idx),
    .any_ready  (any_ready)
  );

  // Next entry state: wakeup, free on issue, allocate with bypass, flush.
  always_comb begin
    entry_d = entry_q;
    in_s    = '0;
    for (int i = 0; i < int'(N_LINE); i++) begin
      if (entry_q[i].busy) begin
        for (int s = 0; s < int'(N_SRC); s++) entry_d[i].src[s] = wake_capture(entry_q[i].src[s]);
      end
    end
    if (fire) entry_d[sel_idx].busy = 1'b0;
    if (accept) begin
      entry_d[free_idx].busy    = 1'b1;
      entry_d[free_idx].payload = in_payload;
      for (int s = 0; s < int'(N_SRC); s++) begin
        in_s.valid = in_src_valid[s];
        in_s.tag   = in_src_tag[s*TAG_W +: TAG_W];
        in_s.data  = in_src_data[s*DATA_W +: DATA_W];
        entry_d[free_idx].src[s] = wake_capture(in_s);
      end
    end
    if (kill) begin
      for (int i = 0; i < int'(N_LINE); i++) entry_d[i].busy = 1'b0;
    end
    count_d = kill ? '0 : (count_q + CNT_W'(accept) - CNT_W'(fire));
  end

  // Station state registers; reset only needs to clear occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(N_LINE); i++) entry_q[i].busy <= 1'b0;
      count_q <= '0;
    end else begin
      entry_q <= entry_d;
      count_q <= count_d;
    end
  end

  // Offered entry drives the issue port directly.
  always_comb begin
    issue_payload  = entry_q[sel_idx].payload;
    issue_src_data = '0;
    for (int s = 0; s < int'(N_SRC); s++) begin
      issue_src_data[s*DATA_W +: DATA_W] = entry_q[sel_idx].src[s].data;
    end
    count = count_q;
  end

endmodule
